// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 master: turns a command + write-data stream into classic single
// cycles or incrementing wrapping bursts (4/8/16 beats), returning read data as a pulse stream.
module wb_b3_burst_master #(
  parameter int adr_width = 30,
  parameter int dat_width = 32
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [adr_width-1:0] cmd_adr,
  input  logic                 cmd_we,
  input  logic [1:0]           cmd_len,
  input  logic [3:0]           cmd_sel,
  input  logic [dat_width-1:0] wr_dat,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [dat_width-1:0] rd_dat,
  output logic                 rd_valid,
  output logic                 done,
  output logic [adr_width-1:0] wbm_adr_o,
  output logic [dat_width-1:0] wbm_dat_o,
  output logic [3:0]           wbm_sel_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  input  logic [dat_width-1:0] wbm_dat_i,
  input  logic                 wbm_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t               state;
  logic [4:0]           beats_left;
  logic                 burst;
  logic [adr_width-1:0] adr;
  logic [3:0]           sel;
  logic [1:0]           bte;
  logic                 we;
  logic                 cyc;
  logic                 beat_ack;

  function automatic logic [4:0] beat_count(input logic [1:0] len);
    case (len)
      2'b00:   beat_count = 5'd1;
      2'b01:   beat_count = 5'd4;
      2'b10:   beat_count = 5'd8;
      default: beat_count = 5'd16;
    endcase
  endfunction

  // Wrapping bursts only carry into the low bits of the aligned block.
  function automatic logic [adr_width-1:0] next_adr(input logic [adr_width-1:0] a,
                                                   input logic [1:0]           b);
    logic [adr_width-1:0] inc;
    inc = a + {{(adr_width-1){1'b0}}, 1'b1};
    case (b)
      2'b01:   next_adr = {a[adr_width-1:2], inc[1:0]};
      2'b10:   next_adr = {a[adr_width-1:3], inc[2:0]};
      2'b11:   next_adr = {a[adr_width-1:4], inc[3:0]};
      default: next_adr = inc;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);
  assign wbm_stb_o = cyc & (we ? wr_valid : 1'b1);
  // An ack is only honoured while a strobe is actually presented.
  assign beat_ack  = wbm_stb_o & wbm_ack_i;
  assign wr_ready  = beat_ack & we;

  assign wbm_cyc_o = cyc;
  assign wbm_we_o  = we;
  assign wbm_adr_o = adr;
  assign wbm_sel_o = sel;
  assign wbm_bte_o = bte;
  assign wbm_dat_o = wr_dat;

  always_comb begin
    wbm_cti_o = 3'b000;
    if (cyc && burst) begin
      wbm_cti_o = (beats_left > 5'd1) ? 3'b010 : 3'b111;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state      <= IDLE;
      beats_left <= '0;
      burst      <= 1'b0;
      adr        <= '0;
      sel        <= '0;
      bte        <= '0;
      we         <= 1'b0;
      cyc        <= 1'b0;
      rd_dat     <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            adr        <= cmd_adr;
            we         <= cmd_we;
            sel        <= (cmd_len == 2'b00) ? cmd_sel : 4'b1111;
            bte        <= cmd_len;
            burst      <= (cmd_len != 2'b00);
            beats_left <= beat_count(cmd_len);
            cyc        <= 1'b1;
            state      <= BUS;
          end
        end
        BUS: begin
          if (beat_ack) begin
            beats_left <= beats_left - 5'd1;
            adr        <= next_adr(adr, bte);
            if (!we) begin
              rd_dat   <= wbm_dat_i;
              rd_valid <= 1'b1;
            end
            if (beats_left == 5'd1) begin
              cyc   <= 1'b0;
              we    <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          // One cycle with cyc low guarantees an idle bus cycle between commands.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Scoreboard bench for wb_b3_burst_master driving a byte-enable RAM model with zero-wait acks.
module tb_wb_b3_burst_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [29:0] cmd_adr = '0;
  logic        cmd_we = 1'b0;
  logic [1:0]  cmd_len = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] wr_dat = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_dat;
  logic        rd_valid;
  logic        done;
  logic [29:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  wb_b3_burst_master #(.adr_width(30), .dat_width(32)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr), .cmd_we(cmd_we),
    .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_dat(wr_dat), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_dat(rd_dat), .rd_valid(rd_valid), .done(done),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 wb_clk = ~wb_clk;

  // RAM slave; stray_ack raises ack without a strobe to prove the master ignores it.
  logic [31:0] mem [0:1023];
  logic        clear_mem = 1'b1;
  logic        stray_ack = 1'b0;

  assign wbm_ack_i = wbm_cyc_o & (wbm_stb_o | stray_ack);
  assign wbm_dat_i = mem[wbm_adr_o[9:0]];

  always @(posedge wb_clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o) begin
      for (int b = 0; b < 4; b++)
        if (wbm_sel_o[b]) mem[wbm_adr_o[9:0]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
    end
  end

  typedef struct packed {
    logic [29:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  beat_t       bus_q[$];
  logic [31:0] rd_q[$];
  int          done_q[$];
  logic [31:0] wd [16];
  logic [31:0] rx [16];
  int          vectors = 0;
  int          miscompares = 0;
  int          cmd_id = 0;
  bit          final_req = 1'b0;
  bit          final_ack = 1'b0;
  bit          prev_rst = 1'b0;

  task automatic expect_cmd(input logic [29:0] adr, input logic we, input logic [1:0] len,
                            input logic [3:0] sel, input int pushed, input bit exp_done);
    int          n;
    logic [29:0] mask;
    beat_t       b;
    n    = (len == 2'd0) ? 1 : (len == 2'd1) ? 4 : (len == 2'd2) ? 8 : 16;
    mask = 30'(n - 1);
    for (int i = 0; i < pushed; i++) begin
      b.adr = (adr & ~mask) | ((adr + 30'(i)) & mask);
      b.cti = (n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010;
      b.bte = len;
      b.we  = we;
      b.sel = (n == 1) ? sel : 4'b1111;
      b.dat = we ? wd[i] : 32'h0;
      bus_q.push_back(b);
      if (!we) rd_q.push_back(rx[i]);
    end
    cmd_id++;
    if (exp_done) done_q.push_back(cmd_id);
  endtask

  task automatic die(input string what);
    $display("FAIL timeout %s at %0t", what, $time);
    $fatal(1, "bench stopped");
  endtask

  task automatic issue(input logic [29:0] adr, input logic we, input logic [1:0] len,
                       input logic [3:0] sel);
    bit ok;
    ok        = 1'b0;
    cmd_adr   = adr;
    cmd_we    = we;
    cmd_len   = len;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge wb_clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) die("cmd_accept");
    @(posedge wb_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int stall_at);
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        wr_valid  = 1'b0;
        stray_ack = 1'b1;
        @(posedge wb_clk); #1;
        stray_ack = 1'b0;
        @(posedge wb_clk); #1;
      end
      wr_dat   = wd[i];
      wr_valid = 1'b1;
      ok       = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge wb_clk);
        if (wr_ready) ok = 1'b1;
      end
      if (!ok) die("wr_ready");
      @(posedge wb_clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge wb_clk);
      if (done) ok = 1'b1;
    end
    if (!ok) die("done");
    @(posedge wb_clk); #1;
  endtask

  // Monitor: every observable event is popped against the scoreboard.
  always @(negedge wb_clk) begin
    beat_t got, exp;
    if (!wb_rst) begin
      vectors++;
      if (wbm_cyc_o || wbm_stb_o || wbm_we_o || done || rd_valid || !cmd_ready || wbm_cti_o != 3'b000) begin
        miscompares++;
        $display("FAIL reset_state cyc=%b stb=%b we=%b done=%b rd_valid=%b cmd_ready=%b cti=%b, want 0 0 0 0 0 1 000",
                 wbm_cyc_o, wbm_stb_o, wbm_we_o, done, rd_valid, cmd_ready, wbm_cti_o);
      end
    end else begin
      if (!prev_rst) begin
        vectors++;
        if (!cmd_ready || wbm_cyc_o) begin
          miscompares++;
          $display("FAIL post_reset cmd_ready=%b cyc=%b, want 1 0", cmd_ready, wbm_cyc_o);
        end
      end
      got = '{adr: wbm_adr_o, cti: wbm_cti_o, bte: wbm_bte_o, we: wbm_we_o, sel: wbm_sel_o,
              dat: wbm_we_o ? wbm_dat_o : 32'h0};
      if (wbm_stb_o && wbm_ack_i) begin
        vectors++;
        if (bus_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat got=%h, want none", got);
        end else begin
          exp = bus_q.pop_front();
          if (got !== exp) begin
            miscompares++;
            $display("FAIL bus_beat got adr=%h cti=%b bte=%b we=%b sel=%b dat=%h, want adr=%h cti=%b bte=%b we=%b sel=%b dat=%h",
                     got.adr, got.cti, got.bte, got.we, got.sel, got.dat,
                     exp.adr, exp.cti, exp.bte, exp.we, exp.sel, exp.dat);
          end
        end
      end else if (wbm_cyc_o && !wbm_stb_o && bus_q.size() > 0) begin
        vectors++;
        if (wbm_adr_o !== bus_q[0].adr || wbm_cti_o !== bus_q[0].cti) begin
          miscompares++;
          $display("FAIL stall_hold adr=%h cti=%b, want adr=%h cti=%b",
                   wbm_adr_o, wbm_cti_o, bus_q[0].adr, bus_q[0].cti);
        end
      end
      if (rd_valid) begin
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rd rd_dat=%h, want no rd_valid", rd_dat);
        end else if (rd_dat !== rd_q[0]) begin
          miscompares++;
          $display("FAIL rd_dat got=%h, want %h", rd_dat, rd_q.pop_front());
        end else begin
          void'(rd_q.pop_front());
        end
      end
      if (done) begin
        vectors++;
        if (done_q.size() == 0 || wbm_cyc_o) begin
          miscompares++;
          $display("FAIL done_pulse pending=%0d cyc=%b, want >0 and 0", done_q.size(), wbm_cyc_o);
        end
        if (done_q.size() > 0) void'(done_q.pop_front());
      end
    end
    prev_rst = wb_rst;
    if (final_req && !final_ack) begin
      vectors++;
      if (bus_q.size() != 0 || rd_q.size() != 0 || done_q.size() != 0) begin
        miscompares++;
        $display("FAIL leftover beats=%0d reads=%0d dones=%0d, want 0 0 0",
                 bus_q.size(), rd_q.size(), done_q.size());
      end
      final_ack = 1'b1;
    end
  end

  initial begin
    repeat (3) @(posedge wb_clk);
    #1;
    clear_mem = 1'b0;
    wb_rst    = 1'b1;
    @(posedge wb_clk); #1;

    // single write then single read at byte 0x100
    wd[0] = 32'h12345678;
    expect_cmd(30'h40, 1'b1, 2'b00, 4'b1111, 1, 1'b1);
    issue(30'h40, 1'b1, 2'b00, 4'b1111); feed(1, -1); wait_done();
    rx[0] = 32'h12345678;
    expect_cmd(30'h40, 1'b0, 2'b00, 4'b1111, 1, 1'b1);
    issue(30'h40, 1'b0, 2'b00, 4'b1111); wait_done();

    // beat4 write, then partial-byte single write to word 0x41
    wd[0] = 32'h00010002; wd[1] = 32'h00030004; wd[2] = 32'h00050006; wd[3] = 32'h00070008;
    expect_cmd(30'h40, 1'b1, 2'b01, 4'b0000, 4, 1'b1);
    issue(30'h40, 1'b1, 2'b01, 4'b0000); feed(4, -1); wait_done();
    wd[0] = 32'hA1FFFFFF;
    expect_cmd(30'h41, 1'b1, 2'b00, 4'b1000, 1, 1'b1);
    issue(30'h41, 1'b1, 2'b00, 4'b1000); feed(1, -1); wait_done();

    // wrapping beat4 read from byte 0x108
    rx[0] = 32'h00050006; rx[1] = 32'h00070008; rx[2] = 32'h00010002; rx[3] = 32'hA1030004;
    expect_cmd(30'h42, 1'b0, 2'b01, 4'b0000, 4, 1'b1);
    issue(30'h42, 1'b0, 2'b01, 4'b0000); wait_done();

    // beat8 write with a two-cycle stall before beat 3, read back unaligned
    for (int i = 0; i < 8; i++) wd[i] = 32'h80000000 | i;
    expect_cmd(30'h80, 1'b1, 2'b10, 4'b0000, 8, 1'b1);
    issue(30'h80, 1'b1, 2'b10, 4'b0000); feed(8, 2); wait_done();
    for (int i = 0; i < 8; i++) rx[i] = 32'h80000000 | ((4 + i) & 7);
    expect_cmd(30'h84, 1'b0, 2'b10, 4'b0000, 8, 1'b1);
    issue(30'h84, 1'b0, 2'b10, 4'b0000); wait_done();

    // beat16 write from word 0x4F wraps to 0x40; aligned beat16 readback
    for (int i = 0; i < 16; i++) wd[i] = 32'hC0000000 | i;
    expect_cmd(30'h4F, 1'b1, 2'b11, 4'b0000, 16, 1'b1);
    issue(30'h4F, 1'b1, 2'b11, 4'b0000); feed(16, -1); wait_done();
    for (int k = 0; k < 16; k++) rx[k] = 32'hC0000000 | ((k + 1) & 15);
    expect_cmd(30'h40, 1'b0, 2'b11, 4'b0000, 16, 1'b1);
    issue(30'h40, 1'b0, 2'b11, 4'b0000); wait_done();

    // reset after beat 2 of a beat8 write: no done, remaining beats dropped
    for (int i = 0; i < 8; i++) wd[i] = 32'hD0000000 | i;
    expect_cmd(30'h100, 1'b1, 2'b10, 4'b0000, 2, 1'b0);
    issue(30'h100, 1'b1, 2'b10, 4'b0000); feed(2, -1);
    wb_rst = 1'b0;
    repeat (2) @(posedge wb_clk);
    #1;
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    rx[0] = 32'hD0000000; rx[1] = 32'hD0000001; rx[2] = 32'h0; rx[3] = 32'h0;
    expect_cmd(30'h100, 1'b0, 2'b01, 4'b0000, 4, 1'b1);
    issue(30'h100, 1'b0, 2'b01, 4'b0000); wait_done();

    repeat (3) @(posedge wb_clk);
    #1;
    final_req = 1'b1;
    for (int t = 0; t < 10 && !final_ack; t++) @(posedge wb_clk);
    if (!final_ack) die("final_check");
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
